// File: rtl/stopwatch_button_frontend.sv
// Button front end for the stopwatch: synchronises, debounces and edge-detects
// the run/halt/reset push-buttons into single-cycle, priority-resolved commands.
module stopwatch_button_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic i_clock,
    input  logic i_async_rst_n,
    input  logic i_btn_run,
    input  logic i_btn_halt,
    input  logic i_btn_reset,
    output logic o_trigger_run,
    output logic o_trigger_halt,
    output logic o_soft_reset,
    output logic o_any_held
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit order everywhere: [0]=run, [1]=halt, [2]=reset.
    logic [2:0]       btn_raw;
    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic [1:0]       state_q [3];
    logic [1:0]       state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic [2:0]       press_req;
    logic             held_any;

    assign btn_raw = {i_btn_reset, i_btn_halt, i_btn_run};

    always_ff @(posedge i_clock or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        press_req = '0;
        held_any  = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == ST_HELD || state_q[i] == ST_RELEASE_WAIT) begin
                held_any = 1'b1;
            end
            case (state_q[i])
                ST_IDLE: begin
                    if (sync_q2[i]) begin
                        state_d[i] = ST_PRESS_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync_q2[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i]   = ST_HELD;
                        cnt_d[i]     = '0;
                        press_req[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!sync_q2[i]) begin
                        state_d[i] = ST_RELEASE_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (sync_q2[i]) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Fixed priority reset > halt > run; losing requests are simply dropped.
    always_ff @(posedge i_clock or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            o_soft_reset   <= 1'b0;
            o_trigger_halt <= 1'b0;
            o_trigger_run  <= 1'b0;
            o_any_held     <= 1'b0;
        end else begin
            o_soft_reset   <= press_req[2];
            o_trigger_halt <= press_req[1] & ~press_req[2];
            o_trigger_run  <= press_req[0] & ~press_req[1] & ~press_req[2];
            o_any_held     <= held_any;
        end
    end

endmodule

// File: doc/stopwatch_button_frontend.md
# stopwatch_button_frontend

- Initiator side of the stopwatch run/halt/reset control interface: turns three raw, asynchronous, bouncing push-buttons into clean single-cycle command pulses.
- Outputs drive the control FSM's run trigger, halt trigger and soft-reset inputs directly.
- Each button has a 2-flop synchroniser, a debounce state machine with a stability counter, and press-edge pulse generation; simultaneous commands are resolved by a fixed priority.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a press or release (≥2). Benches override it to 8.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each stability counter.

Ports:
- i_clock  input  1  system clock; the only clock.
- i_async_rst_n  input  1  reset, asynchronous, active-low.
- i_btn_run  input  1  raw start button, active-high, asynchronous to i_clock.
- i_btn_halt  input  1  raw stop button, active-high, asynchronous.
- i_btn_reset  input  1  raw clear button, active-high, asynchronous.
- o_trigger_run  output  1  one-cycle run command pulse.
- o_trigger_halt  output  1  one-cycle halt command pulse.
- o_soft_reset  output  1  one-cycle soft-reset command pulse.
- o_any_held  output  1  high while any button is in HELD or RELEASE_WAIT.

## Operation

- Reset asserted, at any time including mid-debounce: all synchroniser flops 0, all FSMs IDLE, counters 0, all outputs 0. The reset takes effect immediately, without waiting for a clock edge.
- Synchroniser: each raw input passes through two flops; s denotes the second-flop output.
- Per-button FSM, with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT:
  - IDLE: if s==1, go to PRESS_WAIT with cnt<=1; otherwise stay.
  - PRESS_WAIT: if s==0, go to IDLE with cnt<=0 (glitch rejected, no pulse). If s==1 and cnt==DEBOUNCE_CYCLES, go to HELD, cnt<=0, and raise this button's press request. Otherwise cnt<=cnt+1.
  - HELD: if s==0, go to RELEASE_WAIT with cnt<=1; otherwise stay. No further pulses while held.
  - RELEASE_WAIT: if s==1, go to HELD with cnt<=0 (release bounce). If s==0 and cnt==DEBOUNCE_CYCLES, go to IDLE, cnt<=0; no pulse. Otherwise cnt<=cnt+1.
  - Any unused encoding goes to IDLE.
- The counter never exceeds DEBOUNCE_CYCLES and has no wrap-around.
- Command arbitration on the edge where press requests are raised:
  - Priority is reset > halt > run. Only the highest-priority requesting button's output pulses.
  - Lower-priority requests in the same cycle are dropped, not queued; those FSMs still enter HELD.
- Requests in different cycles are independent. Run and halt pulses may occur on consecutive cycles.
- All three outputs are registered; at most one is high in any cycle.
- o_any_held is registered, the OR over buttons of (state==HELD or state==RELEASE_WAIT).
- A button held through reset deassertion is treated as a fresh press, so it yields a pulse after the normal latency.

## Timing

- Edge E0 is the first rising edge at which the raw input is sampled high:
  - s goes high after E1.
  - The FSM enters PRESS_WAIT at E2.
  - The FSM enters HELD at E(2+DEBOUNCE_CYCLES).
  - The pulse is high from E(2+DEBOUNCE_CYCLES) to E(3+DEBOUNCE_CYCLES). With DEBOUNCE_CYCLES=8, the pulse is high between E10 and E11.
- Accepted press requires a raw high of at least DEBOUNCE_CYCLES+1 consecutive samples.
- Accepted release likewise requires DEBOUNCE_CYCLES+1 consecutive low samples.
- o_any_held rises one edge after the pulse edge, at E(3+DEBOUNCE_CYCLES). It falls at the edge after the FSM returns to IDLE.
- Pulse width is always exactly 1 cycle, independent of hold time.

## Test plan (DEBOUNCE_CYCLES=8)

- Clean press: hold i_btn_run high for 40 cycles, then low -> o_trigger_run high for exactly cycle 10 after first sample; no other pulses; o_any_held high from cycle 11 until 10 cycles after release.
- Bounce rejection: i_btn_halt toggles with high periods of 1, 3 and 7 cycles, then stays low -> no o_trigger_halt ever; FSM back in IDLE. Then hold 20 cycles -> exactly one pulse.
- Release bounce: a held run button drops low for 4 cycles, then high again for 20 cycles -> no second o_trigger_run.
- Simultaneous press: all three buttons rise on the same cycle -> only o_soft_reset pulses; after a release and a re-press of i_btn_run alone, o_trigger_run pulses.
- Staggered presses: halt pressed 1 cycle after run -> o_trigger_run at cycle 10, o_trigger_halt at cycle 11.
- Reset mid-debounce: assert i_async_rst_n low at cycle 6 of a press, between clock edges -> outputs 0 immediately. Deassert while the button is still held -> pulse 10 edges after the first post-reset sample.
